// File: rtl/diff_peak_detect_if.sv
// Stream bundle for diff_peak_detect: derivative samples in, peak events out.
interface diff_peak_detect_if #(
    parameter int unsigned DATA_WIDTH  = 17,
    parameter int unsigned INDEX_WIDTH = 16
);
    logic                          in_valid;
    logic                          in_ready;
    logic signed [DATA_WIDTH-1:0]  in_data;
    logic                          out_valid;
    logic                          out_ready;
    logic        [INDEX_WIDTH-1:0] out_index;
    logic        [INDEX_WIDTH-1:0] out_interval;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_index, out_interval
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_index, out_interval
    );
endinterface

// File: rtl/diff_peak_detect.sv
// Detects positive-to-negative derivative sign changes (with hysteresis) and
// emits one event per peak carrying its sample index and the gap to the previous peak.
module diff_peak_detect #(
    parameter int unsigned DATA_WIDTH  = 17,
    parameter int unsigned INDEX_WIDTH = 16,
    parameter int unsigned THRESHOLD   = 0
) (
    input  logic             clk,
    input  logic             reset,
    diff_peak_detect_if.slave bus
);
    localparam int unsigned CMP_WIDTH = DATA_WIDTH + 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RISING  = 2'd1;
    localparam logic [1:0] ST_FALLING = 2'd2;

    logic [1:0]             state_q, state_d;
    logic [INDEX_WIDTH-1:0] idx_q, idx_d;
    logic [INDEX_WIDTH-1:0] last_peak_q, last_peak_d;
    logic                   first_q, first_d;
    logic                   out_valid_q, out_valid_d;
    logic [INDEX_WIDTH-1:0] out_index_q, out_index_d;
    logic [INDEX_WIDTH-1:0] out_interval_q, out_interval_d;

    logic                        in_ready_c;
    logic                        accept_c;
    logic                        fire_c;
    logic                        is_pos_c;
    logic                        is_neg_c;
    logic signed [CMP_WIDTH-1:0] data_ext_c;
    logic signed [CMP_WIDTH-1:0] thr_pos_c;
    logic signed [CMP_WIDTH-1:0] thr_neg_c;

    // One extra bit keeps -THRESHOLD and the most-negative sample free of overflow
    always_comb begin
        data_ext_c = {bus.in_data[DATA_WIDTH-1], bus.in_data};
        thr_pos_c  = CMP_WIDTH'(THRESHOLD);
        thr_neg_c  = -thr_pos_c;
        is_pos_c   = data_ext_c > thr_pos_c;
        is_neg_c   = data_ext_c < thr_neg_c;
    end

    assign in_ready_c       = !out_valid_q || bus.out_ready;
    assign accept_c         = bus.in_valid && in_ready_c;
    assign bus.in_ready     = in_ready_c;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_index    = out_index_q;
    assign bus.out_interval = out_interval_q;

    // Slope FSM, sample counter and single-entry event register
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        last_peak_d    = last_peak_q;
        first_d        = first_q;
        out_valid_d    = out_valid_q;
        out_index_d    = out_index_q;
        out_interval_d = out_interval_q;
        fire_c         = 1'b0;

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept_c) begin
            idx_d = idx_q + 1'b1;
            if (is_pos_c) begin
                state_d = ST_RISING;
            end else if (is_neg_c) begin
                fire_c  = (state_q == ST_RISING);
                state_d = ST_FALLING;
            end
        end

        if (fire_c) begin
            out_valid_d    = 1'b1;
            out_index_d    = idx_q;
            out_interval_d = first_q ? '0 : idx_q - last_peak_q;
            last_peak_d    = idx_q;
            first_d        = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            idx_q          <= '0;
            last_peak_q    <= '0;
            first_q        <= 1'b1;
            out_valid_q    <= 1'b0;
            out_index_q    <= '0;
            out_interval_q <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            last_peak_q    <= last_peak_d;
            first_q        <= first_d;
            out_valid_q    <= out_valid_d;
            out_index_q    <= out_index_d;
            out_interval_q <= out_interval_d;
        end
    end
endmodule
